line_window_buffer: RTL and testbench

- Multi-channel video line buffer that delivers a vertical window of BUF_DEPTH vertically aligned pixels, one per row, every accepted pixel.
- Row 0 is the current line; rows 1..BUF_DEPTH-1 are the same column from previous lines.
- Sits between the pixel source (camera/HDMI deserialiser) and the vertical window stages of 2D filters (convolution, Sobel, median).
- New over the previous generation: packed channels, addressing gated by data-valid, frame-aware fill tracking with top-border handling, and width-overflow detection.

---
 rtl/line_buf_pkg.sv | 23 ++
 rtl/line_mem.sv | 38 +++
 rtl/line_window_buffer.sv | 170 +++++++++++++++++
 tb/tb_line_window_buffer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_buf_pkg.sv
// -----------------------------------------------------------------------------
// line_buf_pkg
// Shared types and constants for the line window buffer.
//   LB_*        : default geometry of the window buffer.
//   pixel_t     : one packed pixel, channel 0 in the LSBs.
//   window_t    : one vertical window, index 0 is the current row.
//   BORDER_*    : top-border fill modes selected by border_i.
// -----------------------------------------------------------------------------
package line_buf_pkg;

  localparam int LB_COLORDEPTH = 8;
  localparam int LB_CHANNELS   = 3;
  localparam int LB_MAX_WIDTH  = 2048;
  localparam int LB_BUF_DEPTH  = 3;
  localparam int LB_PIX_W      = LB_COLORDEPTH * LB_CHANNELS;

  typedef logic [LB_PIX_W-1:0] pixel_t;
  typedef pixel_t window_t [LB_BUF_DEPTH];

  localparam logic BORDER_ZERO = 1'b0;
  localparam logic BORDER_REPL = 1'b1;

endpackage

// File: rtl/line_mem.sv
// -----------------------------------------------------------------------------
// line_mem
// Single-port read-first line memory: o_rdata always shows the word stored at
// i_addr before this cycle's write, so a cascade of these memories shifts a
// column down by one line per accepted pixel.
//   clk     : system clock
//   i_en    : port enable (pixel accepted)
//   i_we    : write enable, qualified by i_en
//   i_addr  : column address
//   i_wdata : word written at i_addr
//   o_rdata : old word at i_addr
// -----------------------------------------------------------------------------
module line_mem #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 24,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_en,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  // NOTE: the array has no reset; clearing a RAM would forbid block/LUT RAM
  // mapping, and stale contents are masked by fill tracking in the top level.
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/line_window_buffer.sv
// -----------------------------------------------------------------------------
// line_window_buffer
// Multi-channel video line buffer producing a vertical window of BUF_DEPTH
// pixels (current row plus the same column of previous lines) per accepted
// pixel, one cycle after acceptance.
//   clk         : system clock
//   rst         : synchronous active-low reset
//   data_i      : input pixel, channel 0 in LSBs
//   dv_i        : data_i valid
//   line_end    : end-of-line pulse (pixel in the same cycle is the last one)
//   frame_start : start-of-frame pulse (pixel in the same cycle is column 0)
//   border_i    : top-border mode, BORDER_ZERO or BORDER_REPL
//   dv_o        : window valid
//   buff_o      : window, row 0 is the current line
//   fill_o      : completed lines held, saturating at BUF_DEPTH-1
//   overflow_o  : sticky, a line exceeded MAX_WIDTH pixels
// -----------------------------------------------------------------------------
module line_window_buffer
  import line_buf_pkg::*;
#(
  parameter int COLORDEPTH = LB_COLORDEPTH,
  parameter int CHANNELS   = LB_CHANNELS,
  parameter int MAX_WIDTH  = LB_MAX_WIDTH,
  parameter int BUF_DEPTH  = LB_BUF_DEPTH,
  parameter int ADDR_W     = $clog2(MAX_WIDTH)   // derived, leave at default
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [CHANNELS*COLORDEPTH-1:0]            data_i,
  input  logic                                      dv_i,
  input  logic                                      line_end,
  input  logic                                      frame_start,
  input  logic                                      border_i,
  output logic                                      dv_o,
  output logic [BUF_DEPTH-1:0][CHANNELS*COLORDEPTH-1:0] buff_o,
  output logic [$clog2(BUF_DEPTH)-1:0]              fill_o,
  output logic                                      overflow_o
);

  localparam int                PIX_W    = CHANNELS * COLORDEPTH;
  localparam int                FILL_W   = $clog2(BUF_DEPTH);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(BUF_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(MAX_WIDTH - 1);

  logic [ADDR_W-1:0] r_addr;
  logic              r_at_end;     // last column written, further pixels drop
  logic              r_line_px;    // at least one pixel accepted this line
  logic [FILL_W-1:0] r_fill;
  logic              r_overflow;
  logic              r_dv;
  logic [PIX_W-1:0]  r_rows [BUF_DEPTH];
  logic [FILL_W-1:0] r_win_fill;   // fill level that applies to r_rows
  logic              r_win_border;

  logic              w_accept;
  logic              w_drop;
  logic [ADDR_W-1:0] w_addr;
  logic [FILL_W-1:0] w_fill;
  logic [PIX_W-1:0]  w_tap [BUF_DEPTH];  // 0: input pixel, k: memory k old word

  // frame_start takes effect in its own cycle so a coincident pixel lands in
  // column 0 of the new frame with an empty history.
  assign w_addr   = frame_start ? '0 : r_addr;
  assign w_fill   = frame_start ? '0 : r_fill;
  assign w_drop   = dv_i && r_at_end && !frame_start;
  assign w_accept = dv_i && !w_drop;
  assign w_tap[0] = data_i;

  // Memory k holds line n-k. It is refreshed only when its source (row k-1)
  // holds real data of this frame, so stale lines never rotate into the window.
  for (genvar k = 1; k < BUF_DEPTH; k++) begin : g_mem
    logic w_we;
    assign w_we = (k <= int'(w_fill) + 1);

    line_mem #(
      .DEPTH (MAX_WIDTH),
      .WIDTH (PIX_W),
      .AW    (ADDR_W)
    ) u_mem (
      .clk     (clk),
      .i_en    (w_accept),
      .i_we    (w_we),
      .i_addr  (w_addr),
      .i_wdata (w_tap[k-1]),
      .o_rdata (w_tap[k])
    );
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr       <= '0;
      r_at_end     <= 1'b0;
      r_line_px    <= 1'b0;
      r_fill       <= '0;
      r_overflow   <= 1'b0;
      r_dv         <= 1'b0;
      r_win_fill   <= '0;
      r_win_border <= BORDER_ZERO;
      for (int k = 0; k < BUF_DEPTH; k++) begin
        r_rows[k] <= '0;
      end
    end else begin
      r_dv <= w_accept;

      if (frame_start) begin
        r_addr     <= w_accept ? ADDR_W'(1) : '0;
        r_at_end   <= 1'b0;
        r_line_px  <= w_accept;
        r_fill     <= '0;
        r_overflow <= 1'b0;
      end else if (line_end) begin
        r_addr    <= '0;
        r_at_end  <= 1'b0;
        r_line_px <= 1'b0;
        if ((r_line_px || w_accept) && (r_fill != FILL_MAX)) begin
          r_fill <= r_fill + FILL_W'(1);
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
      end else begin
        if (w_accept) begin
          r_line_px <= 1'b1;
          // Address saturates: the last column is written, then the line is
          // marked full and further pixels are dropped.
          if (r_addr == ADDR_MAX) begin
            r_at_end <= 1'b1;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
      end

      // Window registers only move on accepted pixels, so buff_o holds
      // while dv_o is low.
      if (w_accept) begin
        r_win_fill   <= w_fill;
        r_win_border <= border_i;
        for (int k = 0; k < BUF_DEPTH; k++) begin
          r_rows[k] <= w_tap[k];
        end
      end
    end
  end

  // Rows above the fill level are not yet valid for this frame: zero them
  // or replicate the oldest valid row.
  // NOTE: every path of the loop assigns buff_o[k], so no latch is inferred.
  always_comb begin
    for (int k = 0; k < BUF_DEPTH; k++) begin
      if (k <= int'(r_win_fill)) begin
        buff_o[k] = r_rows[k];
      end else if (r_win_border == BORDER_REPL) begin
        buff_o[k] = r_rows[r_win_fill];
      end else begin
        buff_o[k] = '0;
      end
    end
  end

  assign dv_o       = r_dv;
  assign fill_o     = r_fill;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_line_window_buffer.sv
// -----------------------------------------------------------------------------
// tb_line_window_buffer
// Scoreboard bench: the driver pushes the expected window for every accepted
// pixel (from a line-history model, plus hand-computed windows at selected
// columns); a negedge monitor pops and compares whenever dv_o is high and
// checks that buff_o holds while dv_o is low.
// -----------------------------------------------------------------------------
module tb_line_window_buffer;
  import line_buf_pkg::*;

  localparam int MW = 16;
  localparam int D  = LB_BUF_DEPTH;
  localparam int PW = LB_PIX_W;

  typedef logic [D-1:0][PW-1:0] win_vec_t;
  typedef struct {
    int       seq;
    win_vec_t win;
    string    name;
  } hand_t;

  logic                          clk = 1'b0;
  logic                          rst = 1'b0;
  pixel_t                        data_i = '0;
  logic                          dv_i = 1'b0;
  logic                          line_end = 1'b0;
  logic                          frame_start = 1'b0;
  logic                          border_i = 1'b0;
  logic                          dv_o;
  logic [D-1:0][PW-1:0]          buff_o;
  logic [$clog2(D)-1:0]          fill_o;
  logic                          overflow_o;

  always #5 clk = ~clk;

  line_window_buffer #(
    .MAX_WIDTH (MW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_i      (data_i),
    .dv_i        (dv_i),
    .line_end    (line_end),
    .frame_start (frame_start),
    .border_i    (border_i),
    .dv_o        (dv_o),
    .buff_o      (buff_o),
    .fill_o      (fill_o),
    .overflow_o  (overflow_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  win_vec_t sb_q[$];
  hand_t    hand_q[$];
  int       push_seq = 0;
  int       pop_seq  = 0;
  int       dv_count = 0;
  bit       exp_acc  = 1'b0;
  bit       exp_dv_d = 1'b0;
  bit       exp_rst_d = 1'b0;
  bit       mon_en   = 1'b0;
  win_vec_t last_exp = '0;

  always @(posedge clk) begin
    exp_dv_d  <= exp_acc;
    exp_rst_d <= !rst;
  end

  always @(negedge clk) begin
    win_vec_t e;
    hand_t    h;
    if (mon_en) begin
      if (exp_rst_d) last_exp = '0;
      check("dv_o_timing", dv_o, exp_dv_d);
      if (dv_o === 1'b1) begin
        dv_count++;
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected_output: got window 0x%0h, expected no output", buff_o);
        end else begin
          e = sb_q.pop_front();
          check("window", buff_o, e);
          last_exp = e;
          if (hand_q.size() > 0 && hand_q[0].seq == pop_seq) begin
            h = hand_q.pop_front();
            check(h.name, buff_o, h.win);
          end
          pop_seq++;
        end
      end else begin
        check("hold_while_idle", buff_o, last_exp);
      end
    end
  end

  // --------------------------------------------------------------------- model
  pixel_t m_cur  [MW];
  pixel_t m_hist [D][MW];   // m_hist[k] = line n-k, k >= 1
  int     m_addr = 0;
  int     m_fill = 0;
  bit     m_at_end = 1'b0;
  bit     m_line_px = 1'b0;
  bit     bord = 1'b0;

  function automatic pixel_t pv(input int v);
    logic [7:0] b;
    b = v[7:0];
    return pixel_t'({LB_CHANNELS{b}});
  endfunction

  function automatic win_vec_t mk(input pixel_t r0, input pixel_t r1, input pixel_t r2);
    win_vec_t w;
    w[0] = r0;
    w[1] = r1;
    w[2] = r2;
    return w;
  endfunction

  task automatic hand(input string name, input win_vec_t w);
    hand_t h;
    h.seq  = push_seq;
    h.win  = w;
    h.name = name;
    hand_q.push_back(h);
  endtask

  // Drive one cycle of inputs and predict the response.
  task automatic step(input pixel_t d, input bit dv, input bit le, input bit fs, input bit b);
    int       f_fill;
    int       f_addr;
    bit       f_end;
    bit       acc;
    window_t  w;
    win_vec_t wv;
    data_i = d; dv_i = dv; line_end = le; frame_start = fs; border_i = b;
    f_fill = fs ? 0 : m_fill;
    f_addr = fs ? 0 : m_addr;
    f_end  = fs ? 1'b0 : m_at_end;
    acc    = dv && !f_end;
    if (acc) begin
      w[0] = d;
      for (int k = 1; k < D; k++) begin
        if (k <= f_fill) w[k] = m_hist[k][f_addr];
        else             w[k] = b ? w[f_fill] : '0;
      end
      for (int k = 0; k < D; k++) wv[k] = w[k];
      sb_q.push_back(wv);
      push_seq++;
      m_cur[f_addr] = d;
    end
    exp_acc = acc;
    if (fs) begin
      m_fill = 0; m_addr = acc ? 1 : 0; m_at_end = 1'b0; m_line_px = acc;
    end else if (le) begin
      if (m_line_px || acc) begin
        for (int k = D - 1; k >= 2; k--)
          for (int c = 0; c < MW; c++) m_hist[k][c] = m_hist[k-1][c];
        for (int c = 0; c < MW; c++) m_hist[1][c] = m_cur[c];
        if (m_fill < D - 1) m_fill++;
      end
      m_addr = 0; m_at_end = 1'b0; m_line_px = 1'b0;
    end else if (acc) begin
      m_line_px = 1'b1;
      if (m_addr == MW - 1) m_at_end = 1'b1;
      else m_addr++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, 1'b0, bord);
  endtask

  task automatic send_line(input int l, input int n, input int hcol, input win_vec_t hwin, input string hname);
    for (int c = 0; c < n; c++) begin
      if (c == hcol) hand(hname, hwin);
      step(pv(l * 16 + c), 1'b1, (c == n - 1), 1'b0, bord);
    end
  endtask

  task automatic do_reset(input bit with_dv);
    rst = 1'b0; data_i = pv(8'hEE); dv_i = with_dv; line_end = 1'b0; frame_start = 1'b0;
    m_addr = 0; m_fill = 0; m_at_end = 1'b0; m_line_px = 1'b0;
    exp_acc = 1'b0;
    @(posedge clk);
    #1;
    check("rst_dv_o", dv_o, 1'b0);
    check("rst_buff_o", buff_o, '0);
    check("rst_fill_o", fill_o, 0);
    check("rst_overflow_o", overflow_o, 1'b0);
    rst = 1'b1; dv_i = 1'b0;
  endtask

  // ------------------------------------------------------------------ stimulus
  initial begin
    int base;
    @(posedge clk);
    #1;
    do_reset(1'b0);
    mon_en = 1'b1;

    // Frame A, zero border.
    bord = BORDER_ZERO;
    step('0, 1'b0, 1'b0, 1'b1, bord);
    send_line(0, 8, 5, mk(pv(8'h05), '0, '0), "l0c5_zero_border");
    check("fill_after_line0", fill_o, 1);
    send_line(1, 8, -1, '0, "");
    check("fill_after_line1", fill_o, 2);
    send_line(2, 8, 5, mk(pv(8'h25), pv(8'h15), pv(8'h05)), "l2c5_full_window");
    send_line(3, 8, -1, '0, "");
    check("fill_saturates", fill_o, 2);
    idle(2);

    // Frame B, replicate border.
    bord = BORDER_REPL;
    step('0, 1'b0, 1'b0, 1'b1, bord);
    check("fill_after_frame_start_b", fill_o, 0);
    send_line(0, 8, 3, mk(pv(8'h03), pv(8'h03), pv(8'h03)), "l0c3_repl_border");
    send_line(1, 8, 3, mk(pv(8'h13), pv(8'h03), pv(8'h03)), "l1c3_repl_border");
    check("fill_after_b_line1", fill_o, 2);

    // frame_start mid-frame: history must not leak into the window.
    bord = BORDER_ZERO;
    step('0, 1'b0, 1'b0, 1'b1, bord);
    check("fill_after_mid_frame_start", fill_o, 0);
    send_line(5, 8, 3, mk(pv(8'h53), '0, '0), "fs_mid_frame_zero_rows");

    // dv_i toggling within a line.
    for (int c = 0; c < 8; c++) begin
      if (c == 2) hand("toggle_c2", mk(pv(8'h62), pv(8'h52), '0));
      if (c == 7) hand("toggle_c7", mk(pv(8'h67), pv(8'h57), '0));
      step(pv(8'h60 + c), 1'b1, (c == 7), 1'b0, bord);
      if (c != 7) idle(1);
    end
    idle(2);

    // Width overflow: 20 pixels into a 16-column memory.
    step('0, 1'b0, 1'b0, 1'b1, bord);
    check("ovf_clear_at_start", overflow_o, 1'b0);
    base = dv_count;
    for (int c = 0; c < 20; c++) begin
      if (c == 15) hand("ovf_last_column", mk(pv(8'h7F), '0, '0));
      step(pv(8'h70 + c), 1'b1, (c == 19), 1'b0, bord);
      if (c == 15) check("ovf_before_drop", overflow_o, 1'b0);
      if (c == 16) check("ovf_first_drop", overflow_o, 1'b1);
    end
    idle(2);
    check("ovf_dv_pulse_count", dv_count - base, 16);
    check("ovf_sticky", overflow_o, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1, bord);
    check("ovf_cleared_by_frame_start", overflow_o, 1'b0);

    // Reset mid-line, then the first line behaves as line 0.
    send_line(8, 8, -1, '0, "");
    for (int c = 0; c < 4; c++) step(pv(8'h90 + c), 1'b1, 1'b0, 1'b0, bord);
    do_reset(1'b1);
    bord = BORDER_REPL;
    send_line(9, 8, 4, mk(pv(8'h94), pv(8'h94), pv(8'h94)), "after_rst_line0");
    check("fill_after_rst_line", fill_o, 1);
    idle(3);

    check("sb_drained", sb_q.size(), 0);
    check("hand_drained", hand_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
